// File: rtl/pid_mc_if.sv
// Wishbone slave bus for the multi-channel PID block: 16-bit byte address, 32-bit data.
interface pid_mc_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [15:0] i_wb_adr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
    input  o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
    output o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/pid_mc.sv
// NCH-channel PID controller sharing one multiplier, with per-channel Wishbone registers.
// Latency: o_valid 6 cycles after the pv ack; backpressure: pv writes hold off ack while busy.
module pid_mc #(
  parameter int DW  = 16,
  parameter int AW  = 32,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pid_mc_if.slave              wb,
  output logic signed [AW-1:0] o_un,
  output logic                 o_valid,
  output logic [CW-1:0]        o_ch
);
  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MI, S_MP, S_MD, S_SAT} state_t;
  localparam logic signed [AW-1:0] LIM_MAX = {1'b0, {(AW-1){1'b1}}};

  state_t state_q, state_d;

  logic signed [DW-1:0] kp_r [NCH], ki_r [NCH], kd_r [NCH], sp_r [NCH], pv_r [NCH];
  logic signed [DW-1:0] kpd_r [NCH], e0_r [NCH], e1_r [NCH];
  logic signed [AW-1:0] un_r [NCH], sigma_r [NCH], limit_r [NCH];
  logic [4:0]           of_r [NCH];
  logic                 sat_en_r [NCH];

  logic                 go_q;
  logic [CW-1:0]        cur_ch;
  logic signed [DW-1:0] e0_w, e1_w;
  logic                 of1_w, of3_w, of4_w;
  logic signed [AW-1:0] sig_w;
  logic signed [AW:0]   acc_q;

  function automatic logic [31:0] sx_dw(input logic signed [DW-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sx_aw(input logic signed [AW-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic oor(input logic signed [AW:0] v, input logic signed [AW-1:0] lim);
    logic signed [AW:0] lx;
    lx = {lim[AW-1], lim};
    return (v > lx) || (v < -lx);
  endfunction

  function automatic logic signed [AW-1:0] clampv(input logic signed [AW:0] v,
                                                  input logic signed [AW-1:0] lim);
    logic signed [AW:0] lx;
    lx = {lim[AW-1], lim};
    if (v > lx) return lim;
    else if (v < -lx) return -lim;
    else return v[AW-1:0];
  endfunction

  // Address decode and Wishbone handshake
  logic [13:0]          word;
  logic [CW-1:0]        a_ch;
  logic [3:0]           a_reg;
  logic                 a_ok, busy, stall, xfer, wr;
  logic signed [DW-1:0] wd, kpd_a, kpd_b;
  logic signed [DW:0]   kpd_sum;
  logic [31:0]          rdata;
  logic                 unused_ok;

  assign word      = wb.i_wb_adr[15:2];
  assign a_ch      = word[CW+3:4];
  assign a_reg     = word[3:0];
  assign a_ok      = ({1'b0, a_ch} < (CW+1)'(NCH));
  assign busy      = (state_q != S_IDLE) | go_q;
  assign stall     = wb.i_wb_we & a_ok & (a_reg == 4'd4) & busy;
  assign xfer      = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack & ~stall;
  assign wr        = xfer & wb.i_wb_we & a_ok;
  assign wd        = wb.i_wb_data[DW-1:0];
  assign kpd_a     = (a_reg == 4'd0) ? wd : kp_r[a_ch];
  assign kpd_b     = (a_reg == 4'd2) ? wd : kd_r[a_ch];
  assign kpd_sum   = {kpd_a[DW-1], kpd_a} + {kpd_b[DW-1], kpd_b};
  assign unused_ok = ^{wb.i_wb_adr, wb.i_wb_data};

  always_comb begin
    rdata = '0;
    if (a_ok) begin
      case (a_reg)
        4'd0:    rdata = sx_dw(kp_r[a_ch]);
        4'd1:    rdata = sx_dw(ki_r[a_ch]);
        4'd2:    rdata = sx_dw(kd_r[a_ch]);
        4'd3:    rdata = sx_dw(sp_r[a_ch]);
        4'd4:    rdata = sx_dw(pv_r[a_ch]);
        4'd5:    rdata = sx_dw(kpd_r[a_ch]);
        4'd6:    rdata = sx_dw(e0_r[a_ch]);
        4'd7:    rdata = sx_dw(e1_r[a_ch]);
        4'd8:    rdata = sx_aw(un_r[a_ch]);
        4'd9:    rdata = sx_aw(sigma_r[a_ch]);
        4'd10:   rdata = 32'(of_r[a_ch]);
        4'd11:   rdata = sx_aw(limit_r[a_ch]);
        4'd12:   rdata = 32'(sat_en_r[a_ch]);
        default: rdata = '0;
      endcase
    end
  end

  // Shared multiplier: operands chosen by the current FSM step
  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x, add_a, s_cl, u_fin;
  logic signed [AW:0]     sum_w;
  logic signed [DW:0]     diff;
  logic                   sub, sum_ovf, s_hit, u_hit;

  always_comb begin
    mul_a = e0_w;
    mul_b = ki_r[cur_ch];
    add_a = sigma_r[cur_ch];
    sub   = 1'b0;
    case (state_q)
      S_MP: begin
        mul_b = kpd_r[cur_ch];
        add_a = acc_q[AW-1:0];
      end
      S_MD: begin
        mul_a = e1_w;
        mul_b = kd_r[cur_ch];
        add_a = acc_q[AW-1:0];
        sub   = 1'b1;
      end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_x  = AW'(prod);
  assign sum_w   = sub ? ({add_a[AW-1], add_a} - {prod_x[AW-1], prod_x})
                       : ({add_a[AW-1], add_a} + {prod_x[AW-1], prod_x});
  assign sum_ovf = sum_w[AW] ^ sum_w[AW-1];
  assign diff    = {sp_r[cur_ch][DW-1], sp_r[cur_ch]} - {pv_r[cur_ch][DW-1], pv_r[cur_ch]};
  assign s_cl    = sat_en_r[cur_ch] ? clampv(sum_w, limit_r[cur_ch]) : sum_w[AW-1:0];
  assign s_hit   = sat_en_r[cur_ch] & oor(sum_w, limit_r[cur_ch]);
  assign u_fin   = sat_en_r[cur_ch] ? clampv(acc_q, limit_r[cur_ch]) : acc_q[AW-1:0];
  assign u_hit   = sat_en_r[cur_ch] & oor(acc_q, limit_r[cur_ch]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_q) state_d = S_ERR;
      S_ERR:   state_d = S_MI;
      S_MI:    state_d = S_MP;
      S_MP:    state_d = S_MD;
      S_MD:    state_d = S_SAT;
      S_SAT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Working copies keep register reads stable until the SAT commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_w <= '0; e1_w <= '0; of1_w <= 1'b0; of3_w <= 1'b0; of4_w <= 1'b0;
      sig_w <= '0; acc_q <= '0; o_un <= '0; o_valid <= 1'b0; o_ch <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        S_ERR: begin
          e0_w  <= diff[DW-1:0];
          e1_w  <= e0_r[cur_ch];
          of1_w <= diff[DW] ^ diff[DW-1];
        end
        S_MI: begin
          sig_w <= s_cl;
          acc_q <= {s_cl[AW-1], s_cl};
          of4_w <= of_r[cur_ch][4] | sum_ovf | s_hit;
        end
        S_MP: begin
          acc_q <= sum_w;
          of3_w <= of4_w | sum_ovf;
        end
        S_MD: begin
          acc_q <= sum_w;
          of3_w <= of3_w | sum_ovf;
        end
        S_SAT: begin
          o_un    <= u_fin;
          o_ch    <= cur_ch;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        kp_r[c] <= '0; ki_r[c] <= '0; kd_r[c] <= '0; sp_r[c] <= '0; pv_r[c] <= '0;
        kpd_r[c] <= '0; e0_r[c] <= '0; e1_r[c] <= '0; un_r[c] <= '0; sigma_r[c] <= '0;
        limit_r[c] <= LIM_MAX; of_r[c] <= '0; sat_en_r[c] <= 1'b0;
      end
      go_q         <= 1'b0;
      cur_ch       <= '0;
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= '0;
    end else begin
      wb.o_wb_ack <= xfer;
      if (xfer && !wb.i_wb_we) wb.o_wb_data <= rdata;
      if (state_q == S_IDLE && go_q) go_q <= 1'b0;
      if (state_q == S_SAT) begin
        sigma_r[cur_ch] <= sig_w;
        un_r[cur_ch]    <= u_fin;
        e0_r[cur_ch]    <= e0_w;
        e1_r[cur_ch]    <= e1_w;
        of_r[cur_ch]    <= {of4_w, of3_w | u_hit, of_r[cur_ch][1], of1_w, of_r[cur_ch][0]};
      end
      if (wr) begin
        case (a_reg)
          4'd0: begin
            kp_r[a_ch] <= wd; kpd_r[a_ch] <= kpd_sum[DW-1:0];
            of_r[a_ch][0] <= kpd_sum[DW] ^ kpd_sum[DW-1];
          end
          4'd1: ki_r[a_ch] <= wd;
          4'd2: begin
            kd_r[a_ch] <= wd; kpd_r[a_ch] <= kpd_sum[DW-1:0];
            of_r[a_ch][0] <= kpd_sum[DW] ^ kpd_sum[DW-1];
          end
          4'd3: sp_r[a_ch] <= wd;
          4'd4: begin
            pv_r[a_ch] <= wd;
            go_q       <= 1'b1;
            cur_ch     <= a_ch;
          end
          4'd10:   of_r[a_ch]     <= '0;
          4'd11:   limit_r[a_ch]  <= AW'($signed(wb.i_wb_data));
          4'd12:   sat_en_r[a_ch] <= wb.i_wb_data[0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pid_mc.sv
// Scoreboard bench for pid_mc: a behavioural PID model predicts each o_un, checked on o_valid.
module tb_pid_mc;
  logic               clk, rst;
  logic signed [31:0] o_un;
  logic               o_valid;
  logic [1:0]         o_ch;

  pid_mc_if bus();

  pid_mc #(.DW(16), .AW(32), .NCH(4)) dut (
    .clk(clk), .rst(rst), .wb(bus), .o_un(o_un), .o_valid(o_valid), .o_ch(o_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0, n_bad = 0, cyc_cnt = 0, last_ack = 0;
  int sb_un[$], sb_ch[$], ack_q[$];
  int m_kp[4], m_ki[4], m_kd[4], m_sp[4], m_e0[4], m_e1[4], m_sigma[4], m_lim[4];
  bit m_sat[4];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_pv(input int ch, input int pv, output int u);
    longint s, a, uu;
    int e0n, kpd;
    e0n = int'(shortint'(m_sp[ch] - pv));
    kpd = int'(shortint'(m_kp[ch] + m_kd[ch]));
    m_e1[ch] = m_e0[ch];
    m_e0[ch] = e0n;
    s  = longint'(m_sigma[ch]) + longint'(e0n) * m_ki[ch];
    s  = m_sat[ch] ? clampl(s, m_lim[ch]) : longint'(int'(s));
    a  = s + longint'(e0n) * kpd;
    uu = a - longint'(m_e1[ch]) * m_kd[ch];
    uu = m_sat[ch] ? clampl(uu, m_lim[ch]) : longint'(int'(uu));
    m_sigma[ch] = int'(s);
    u = int'(uu);
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb_un.size() == 0) chk("spurious_valid", o_valid, 0);
      else begin
        chk("o_un", o_un, sb_un.pop_front());
        chk("o_ch", o_ch, sb_ch.pop_front());
        if (ack_q.size() != 0) chk("valid_latency", cyc_cnt - ack_q.pop_front(), 6);
      end
    end
  end

  task automatic wb_xfer(input bit we, input int ch, input int r, input logic [31:0] wdat,
                         input int max_cyc, output logic [31:0] rdat, output bit acked);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_adr  = 16'((ch * 16 + r) * 4);
    bus.i_wb_data = wdat;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < max_cyc && !acked; i++) begin
      @(posedge clk); #1;
      if (bus.o_wb_ack) begin
        acked    = 1'b1;
        rdat     = bus.o_wb_data;
        last_ack = cyc_cnt;
      end
    end
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] dat);
    logic [31:0] d;
    bit a;
    wb_xfer(1'b1, ch, r, dat, 40, d, a);
    chk("wr_ack", a, 1);
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bit a;
    wb_xfer(1'b0, ch, r, 32'h0, 40, d, a);
    if (!a) chk("rd_ack", a, 1);
    else chk(tag, d, exp);
  endtask

  task automatic cfg(input int ch, input int kp, input int ki, input int kd, input int sp);
    wr(ch, 0, kp); wr(ch, 1, ki); wr(ch, 2, kd); wr(ch, 3, sp);
    m_kp[ch] = kp; m_ki[ch] = ki; m_kd[ch] = kd; m_sp[ch] = sp;
  endtask

  task automatic set_sat(input int ch, input int lim, input bit en);
    wr(ch, 11, lim); wr(ch, 12, {31'b0, en});
    m_lim[ch] = lim; m_sat[ch] = en;
  endtask

  task automatic pv_go(input int ch, input int pv);
    logic [31:0] d;
    bit a;
    int u;
    model_pv(ch, pv, u);
    sb_un.push_back(u);
    sb_ch.push_back(ch);
    wb_xfer(1'b1, ch, 4, pv, 40, d, a);
    chk("pv_ack", a, 1);
    if (a) ack_q.push_back(last_ack);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_un.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb_un.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit a;
    int t1;
    for (int c = 0; c < 4; c++) begin
      m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_sp[c] = 0; m_e0[c] = 0; m_e1[c] = 0;
      m_sigma[c] = 0; m_lim[c] = 32'h7FFF_FFFF; m_sat[c] = 1'b0;
    end
    rst = 1'b1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_adr = '0;   bus.i_wb_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_o_un", o_un, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ch", o_ch, 0);
    chk("rst_ack", bus.o_wb_ack, 0);
    chk("rst_rdata", bus.o_wb_data, 0);
    rd(0, 11, 32'h7FFF_FFFF, "rst_limit");
    rd(1, 0, 32'h0, "rst_kp");

    cfg(0, 'h80, 5, 5, 'hF87);
    pv_go(0, 0);
    drain();
    rd(0, 8, 32'h0008_5EC6, "s1_un");
    rd(0, 9, 19875, "s1_sigma");
    rd(0, 5, 32'h85, "s1_kpd");
    rd(0, 6, 32'hF87, "s1_e0");
    rd(0, 10, 0, "s1_of");

    pv_go(0, 'h85E);
    drain();
    rd(0, 6, 1833, "s2_e0");
    rd(0, 7, 3975, "s2_e1");
    rd(0, 9, 29040, "s2_sigma");
    rd(0, 8, 252954, "s2_un");

    cfg(1, 'h80, 5, 5, 'hF87);
    pv_go(1, 0);
    drain();
    rd(1, 8, 32'h0008_5EC6, "ch1_un");
    rd(0, 0, 32'h80, "ch0_kp_kept");
    rd(0, 8, 252954, "ch0_un_kept");
    wr(3, 13, 32'hFFFF_FFFF);
    rd(3, 13, 0, "ch3_r13");

    set_sat(0, 1000, 1'b1);
    pv_go(0, 0);
    drain();
    rd(0, 8, 1000, "sat_un");
    rd(0, 9, 1000, "sat_sigma");
    rd(0, 10, 32'h18, "sat_of");
    wr(0, 10, 32'h0);
    rd(0, 10, 0, "of_clear");

    wr(2, 0, 32'h7FFF);
    wr(2, 2, 32'h1);
    rd(2, 5, 32'hFFFF_8000, "kpd_wrap");
    rd(2, 10, 1, "of0_set");
    cfg(2, 3, 2, 1, 100);
    rd(2, 10, 0, "of0_recalc");

    pv_go(0, 0);
    t1 = last_ack;
    pv_go(2, 10);
    chk("stall_gap", last_ack - t1, 7);
    drain();
    rd(2, 6, 90, "ch2_e0");

    pv_go(1, 5);
    wb_xfer(1'b1, 2, 4, 32'd40, 3, d, a);
    chk("cancel_noack", a, 0);
    drain();
    repeat (10) @(posedge clk);
    #1;
    rd(2, 6, 90, "cancel_e0");
    rd(2, 4, 10, "cancel_pv");

    wb_xfer(1'b1, 1, 4, 32'd7, 40, d, a);
    chk("abort_pv_ack", a, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_o_un", o_un, 0);
    chk("abort_o_ch", o_ch, 0);
    chk("abort_o_valid", o_valid, 0);
    chk("abort_ack", bus.o_wb_ack, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_o_un_after", o_un, 0);
    rd(0, 11, 32'h7FFF_FFFF, "abort_limit");
    rd(1, 8, 0, "abort_un");
    rd(1, 6, 0, "abort_e0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pid_mc.md
# pid_mc

Multi-channel PID controller with a Wishbone slave register interface; the parametrised successor to the single-channel PID block. It holds NCH independent channel contexts (gains, setpoint, error history, integrator, flags) and computes each channel's control output on a single shared multiplier, sequenced by an FSM. It sits behind the Wishbone master on the control bus, with the output tagged by channel for the actuator drivers.

## Interface
- DW, 16: signed width of gains, setpoint, process value and error.
- AW, 32: signed accumulator/output width; AW >= 2*DW is mandatory.
- NCH, 4: channel count, a power of two, 1..16.
- CW, $clog2(NCH) (min 1): channel index width.

- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_adr  in  16  byte address; word = adr[15:2], channel = word[CW+3:4], register = word[3:0].
- i_wb_data  in  32  write data; the low DW bits are used (AW bits for register 11).
- o_wb_ack  out  1  transfer acknowledge.
- o_wb_data  out  32  read data.
- o_un  out  AW  last committed control output.
- o_valid  out  1  one-cycle pulse when o_un is updated.
- o_ch  out  CW  channel index of o_un.

## Operation
Per-channel register map. DW-bit values read back sign-extended to 32 bits.
- 0 kp: RW.
- 1 ki: RW.
- 2 kd: RW.
- 3 sp: RW.
- 4 pv: RW; a write starts a computation for that channel.
- 5 kpd: RO, kp+kd (DW bits, wraps); of[0] is recomputed on every kp/kd write.
- 6 e0: RO.
- 7 e1: RO, the previous e0.
- 8 un: RO.
- 9 sigma: RO.
- 10 of[4:0]: RO; writing any value clears all five bits.
- 11 limit: RW; AW-bit positive saturation bound.
- 12 ctrl: RW; bit0 = sat_en.
- 13-15 and channel >= NCH: read 0, writes ignored, acked normally.

Computation FSM: IDLE -> ERR -> MI -> MP -> MD -> SAT -> IDLE.
- ERR: e1<=e0, e0<=sp-pv (DW bits, wraps); of[1]=signed overflow of sp-pv. of[2]<=old of[1].
- MI: p=e0*ki, sign-extended to AW; s=sigma+p. of[4] is sticky on AW overflow.
  - If sat_en, clamp s to [-limit, +limit] and set of[4]; this is anti-windup.
- MP: a=s+e0*kpd; of[3]=of[4] | AW overflow.
- MD: u=a-e1*kd; of[3] |= AW overflow.
- SAT: if sat_en, clamp u to +/-limit and set of[3] on clamping. Commit sigma<=s, un<=u, o_un<=u, o_ch<=channel; pulse o_valid.
- Without sat_en, all sums wrap two's-complement.
- sigma/un/e0/e1/of update atomically; reads mid-computation return the prior committed values.

Wishbone handshake:
- ack = cyc & stb & ~ack, registered; one ack per transfer. ack is deasserted the cycle after assertion.
- A write to pv while the FSM is not IDLE is stalled: ack is withheld until the FSM returns to IDLE, then the transfer is accepted normally.
- All other accesses never stall, including writes to the busy channel's gains. The new gains take effect in the next computation unless they are written before the MI state reads them; the bench must not depend on that race.
- Dropping cyc or stb while a transfer is stalled cancels it; no computation starts.

## Timing
- Reset values: all registers 0 except limit = 2^(AW-1)-1. FSM is IDLE. o_wb_ack, o_wb_data, o_un, o_valid and o_ch are 0.
- The pv write is acked at edge T. The FSM sits in ERR at T+1, MI at T+2, MP at T+3, MD at T+4 and SAT at T+5. o_valid is high and o_un is valid during T+6.
- Back-to-back pv writes have a throughput of one computation per 7 cycles.
- Read data is registered and valid in the ack cycle.
- Reset during a computation aborts it: no o_valid is generated and no state is committed.

## Test plan
- Ch0: write kp=0x80, ki=5, kd=5, sp=0xF87, pv=0 -> o_valid on the 6th cycle after the pv ack; un=0x00085EC6, sigma=19875, kpd=0x85, e0=0xF87.
- Same channel, then write pv=0x85E -> e0=1833, e1=3975, sigma=29040, un=252954.
- Ch0 as in the first scenario, then set limit=1000 and sat_en=1, then write pv=0 -> un=1000, of[3]=1, sigma clamped to 1000 with of[4]=1. Writing register 10 clears of to 0.
- Configure ch1 identically and write ch1 pv=0 -> o_ch=1 and the same un as ch0. Ch0 registers are unchanged; ch3 register 13 reads 0.
- Write ch0 pv, then immediately write ch2 pv -> the second ack is delayed until the FSM is IDLE. Two o_valid pulses occur 7 cycles apart, with o_ch = 0 and then 2.
- Assert rst at T+3 of a computation -> no o_valid. All outputs are 0 and limit reads 0x7FFFFFFF.
